// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parametrised pipeline-boundary register chain.
// Each stage carries {valid, control, payload, destination register}.
// Supports stall (hold), flush (kill all in-flight entries) and a
// registered occupancy count. Control is forced to zero on bubbles.
//
// Build option: define PIPE_BUBBLE_COLLAPSE_EN to let entries upstream of
// a bubble keep advancing while the output stage is stalled.
module pipe_stage_chain #(
  parameter int DEPTH  = 1,
  parameter int CTRL_W = 2,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic              stall,
  input  logic              flush,
  output logic              in_ready,
  output logic              out_valid,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] rd_out,
  output logic [CNT_W-1:0]  occupancy
);

  // Stage registers
  logic [DEPTH-1:0]  v_r;
  logic [CTRL_W-1:0] ctrl_r [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];
  logic [ADDR_W-1:0] rd_r   [DEPTH];
  logic [CNT_W-1:0]  occ_r;

  // Upstream source seen by each stage (stage 0 sees the chain inputs)
  logic [DEPTH-1:0]  prev_v_s;
  logic [CTRL_W-1:0] prev_ctrl_s [DEPTH];
  logic [DATA_W-1:0] prev_data_s [DEPTH];
  logic [ADDR_W-1:0] prev_rd_s   [DEPTH];

  // Next-state values
  logic [DEPTH-1:0]  v_nxt_s;
  logic [CTRL_W-1:0] ctrl_nxt_s [DEPTH];
  logic [DATA_W-1:0] data_nxt_s [DEPTH];
  logic [ADDR_W-1:0] rd_nxt_s   [DEPTH];
  logic [CNT_W-1:0]  occ_nxt_s;

  // Per-stage advance enables and occupancy deltas
  logic [DEPTH-1:0]  adv_s;
  logic              inc_s;
  logic              dec_s;

  // Route each stage's upstream neighbour (or the chain inputs) to its load path
  always_comb begin
    prev_v_s       = {DEPTH{1'b0}};
    prev_v_s[0]    = in_valid;
    prev_ctrl_s[0] = ctrl_in;
    prev_data_s[0] = data_in;
    prev_rd_s[0]   = rd_in;
    for (int i = 1; i < DEPTH; i++) begin
      prev_v_s[i]    = v_r[i-1];
      prev_ctrl_s[i] = ctrl_r[i-1];
      prev_data_s[i] = data_r[i-1];
      prev_rd_s[i]   = rd_r[i-1];
    end
  end

`ifdef PIPE_BUBBLE_COLLAPSE_EN
  // Advance enables: a stage may load when it is empty or its own entry moves on,
  // so the set of advancing stages is always a contiguous run starting at stage 0
  always_comb begin : adv_collapse
    logic carry;
    carry = ~v_r[DEPTH-1] | ~stall;
    adv_s = {DEPTH{1'b0}};
    adv_s[DEPTH-1] = carry;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      carry    = ~v_r[i] | carry;
      adv_s[i] = carry;
    end
  end
`else
  // Advance enables: a stall freezes the entire chain
  always_comb begin
    adv_s = {DEPTH{~stall}};
  end
`endif

  // Next-state per stage: flush kills valid/control, payload and rd still follow advance
  always_comb begin
    v_nxt_s = v_r;
    for (int i = 0; i < DEPTH; i++) begin
      ctrl_nxt_s[i] = ctrl_r[i];
      data_nxt_s[i] = data_r[i];
      rd_nxt_s[i]   = rd_r[i];
      if (flush) begin
        v_nxt_s[i]    = 1'b0;
        ctrl_nxt_s[i] = {CTRL_W{1'b0}};
      end else if (adv_s[i]) begin
        v_nxt_s[i]    = prev_v_s[i];
        ctrl_nxt_s[i] = prev_ctrl_s[i];
      end else begin
        v_nxt_s[i]    = v_r[i];
        ctrl_nxt_s[i] = ctrl_r[i];
      end
      if (adv_s[i]) begin
        data_nxt_s[i] = prev_data_s[i];
        rd_nxt_s[i]   = prev_rd_s[i];
      end else begin
        data_nxt_s[i] = data_r[i];
        rd_nxt_s[i]   = rd_r[i];
      end
    end
  end

  // Occupancy update: +1 on a real capture, -1 when a real entry leaves the last stage
  always_comb begin
    inc_s = in_valid & adv_s[0];
    dec_s = v_r[DEPTH-1] & adv_s[DEPTH-1] & ~stall;
    if (flush) begin
      occ_nxt_s = {CNT_W{1'b0}};
    end else begin
      occ_nxt_s = occ_r + CNT_W'(inc_s) - CNT_W'(dec_s);
    end
  end

  // Stage and occupancy registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_r   <= {DEPTH{1'b0}};
      occ_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_r[i] <= {CTRL_W{1'b0}};
        data_r[i] <= {DATA_W{1'b0}};
        rd_r[i]   <= {ADDR_W{1'b0}};
      end
    end else begin
      v_r   <= v_nxt_s;
      occ_r <= occ_nxt_s;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_r[i] <= ctrl_nxt_s[i];
        data_r[i] <= data_nxt_s[i];
        rd_r[i]   <= rd_nxt_s[i];
      end
    end
  end

  // Outputs come straight from the last stage; control is gated so a bubble never writes back
  assign in_ready  = reset & adv_s[0];
  assign out_valid = v_r[DEPTH-1];
  assign ctrl_out  = ctrl_r[DEPTH-1] & {CTRL_W{v_r[DEPTH-1]}};
  assign data_out  = data_r[DEPTH-1];
  assign rd_out    = rd_r[DEPTH-1];
  assign occupancy = occ_r;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (base build).
// Two instances share stimulus: DEPTH=1 and DEPTH=3. A queue-based model
// (push new entry at the front, drop the oldest at the back) predicts outputs.
module tb_pipe_stage_chain;
  localparam int CW = 2;
  localparam int DW = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, stall, flush;
  logic [CW-1:0] ctrl_in;
  logic [DW-1:0] data_in;
  logic [AW-1:0] rd_in;

  logic          a_rdy, a_ov;
  logic [CW-1:0] a_ctrl;
  logic [DW-1:0] a_data;
  logic [AW-1:0] a_rd;
  logic [0:0]    a_occ;
  logic          b_rdy, b_ov;
  logic [CW-1:0] b_ctrl;
  logic [DW-1:0] b_data;
  logic [AW-1:0] b_rd;
  logic [1:0]    b_occ;

  pipe_stage_chain #(.DEPTH(1), .CTRL_W(CW), .DATA_W(DW), .ADDR_W(AW)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ctrl_in(ctrl_in), .data_in(data_in),
    .rd_in(rd_in), .stall(stall), .flush(flush), .in_ready(a_rdy), .out_valid(a_ov),
    .ctrl_out(a_ctrl), .data_out(a_data), .rd_out(a_rd), .occupancy(a_occ));

  pipe_stage_chain #(.DEPTH(3), .CTRL_W(CW), .DATA_W(DW), .ADDR_W(AW)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ctrl_in(ctrl_in), .data_in(data_in),
    .rd_in(rd_in), .stall(stall), .flush(flush), .in_ready(b_rdy), .out_valid(b_ov),
    .ctrl_out(b_ctrl), .data_out(b_data), .rd_out(b_rd), .occupancy(b_occ));

  wire [72:0] act1 = {a_ov, a_ctrl, a_rd, a_data, a_occ};
  wire [73:0] act3 = {b_ov, b_ctrl, b_rd, b_data, b_occ};

  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [AW-1:0] r;
  } ent_t;

  ent_t q1[$];
  ent_t q3[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic model_clear();
    q1.delete();
    q3.delete();
    q1.push_back('0);
    for (int i = 0; i < 3; i++) q3.push_back('0);
  endtask

  // One clock edge of the model: unless stalled, the input enters and the oldest entry leaves
  task automatic model_edge();
    ent_t e;
    e = {in_valid, ctrl_in, data_in, rd_in};
    if (!stall) begin
      q1.push_front(e);
      void'(q1.pop_back());
      q3.push_front(e);
      void'(q3.pop_back());
    end
    if (flush) begin
      foreach (q1[i]) begin q1[i].v = 1'b0; q1[i].c = '0; end
      foreach (q3[i]) begin q3[i].v = 1'b0; q3[i].c = '0; end
    end
  endtask

  function automatic int cnt_valid(input ent_t q[$]);
    int n = 0;
    foreach (q[i]) n += int'(q[i].v);
    return n;
  endfunction

  function automatic logic [72:0] exp1();
    ent_t t = q1[0];
    return {t.v, t.c & {CW{t.v}}, t.r, t.d, 1'(cnt_valid(q1))};
  endfunction

  function automatic logic [73:0] exp3();
    ent_t t = q3[2];
    return {t.v, t.c & {CW{t.v}}, t.r, t.d, 2'(cnt_valid(q3))};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!reset) model_clear();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (act1 !== 73'd0) begin n_err++; $display("FAIL reset_d1: got %h expected 0", act1); end
    n_cmp++;
    if (act3 !== 74'd0) begin n_err++; $display("FAIL reset_d3: got %h expected 0", act3); end
    n_cmp++;
    if ({a_rdy, b_rdy} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b expected 00", {a_rdy, b_rdy}); end
  endtask

  task automatic test_single();
    reset = 1'b1; in_valid = 1'b1; ctrl_in = 2'b11; rd_in = 5'd7; data_in = 64'hA5;
    step();
    n_cmp++;
    if (act1 !== {1'b1, 2'b11, 5'd7, 64'hA5, 1'b1}) begin
      n_err++; $display("FAIL single_d1: got %h expected %h", act1, {1'b1, 2'b11, 5'd7, 64'hA5, 1'b1});
    end
    n_cmp++;
    if (act3 !== exp3()) begin n_err++; $display("FAIL single_d3: got %h expected %h", act3, exp3()); end
    in_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_stream();
    int peak = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 3);
      data_in  = 64'(k + 1);
      rd_in    = 5'(k + 1);
      ctrl_in  = 2'(k + 1);
      n_cmp++;
      if (b_rdy !== 1'b1) begin n_err++; $display("FAIL stream_ready: got %b expected 1", b_rdy); end
      step();
      if (int'(b_occ) > peak) peak = int'(b_occ);
      n_cmp++;
      if (act3 !== exp3()) begin n_err++; $display("FAIL stream_d3 k=%0d: got %h expected %h", k, act3, exp3()); end
      n_cmp++;
      if (act1 !== exp1()) begin n_err++; $display("FAIL stream_d1 k=%0d: got %h expected %h", k, act1, exp1()); end
      if (k >= 2 && k <= 4) begin
        n_cmp++;
        if (!b_ov || b_data !== 64'(k - 1)) begin
          n_err++; $display("FAIL stream_order k=%0d: got v=%b d=%0d expected v=1 d=%0d", k, b_ov, b_data, k - 1);
        end
      end
    end
    n_cmp++;
    if (peak != 3) begin n_err++; $display("FAIL stream_peak: got %0d expected 3", peak); end
  endtask

  task automatic test_stall();
    logic [73:0] snap;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; data_in = 64'(10 + k); rd_in = 5'(10 + k); ctrl_in = 2'b01;
      step();
    end
    snap = act3;
    stall = 1'b1; in_valid = 1'b1; data_in = 64'd99;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if ({a_rdy, b_rdy} !== 2'b00) begin n_err++; $display("FAIL stall_ready: got %b expected 00", {a_rdy, b_rdy}); end
      step();
      n_cmp++;
      if (act3 !== snap || act3 !== exp3()) begin
        n_err++; $display("FAIL stall_hold k=%0d: got %h expected %h", k, act3, exp3());
      end
    end
    stall = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (act3 !== exp3()) begin n_err++; $display("FAIL stall_resume k=%0d: got %h expected %h", k, act3, exp3()); end
      if (k < 2) begin
        n_cmp++;
        if (!b_ov || b_data !== 64'(11 + k)) begin
          n_err++; $display("FAIL stall_order k=%0d: got v=%b d=%0d expected v=1 d=%0d", k, b_ov, b_data, 11 + k);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; data_in = 64'(20 + k); ctrl_in = 2'b11; rd_in = 5'(20 + k);
      step();
    end
    flush = 1'b1; stall = 1'b1; in_valid = 1'b1; data_in = 64'd77;
    step();
    n_cmp++;
    if ({b_ov, b_ctrl, b_occ, a_ov, a_ctrl, a_occ} !== 9'd0) begin
      n_err++; $display("FAIL flush_kill: got %b expected 0", {b_ov, b_ctrl, b_occ, a_ov, a_ctrl, a_occ});
    end
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (b_ov !== 1'b0 || act3 !== exp3()) begin
        n_err++; $display("FAIL flush_after k=%0d: got %h expected %h", k, act3, exp3());
      end
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; data_in = 64'h33; ctrl_in = 2'b10; rd_in = 5'd3;
    repeat (2) step();
    stall = 1'b1;
    step();
    #2 reset = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (act1 !== 73'd0 || act3 !== 74'd0) begin
      n_err++; $display("FAIL async_reset: got %h/%h expected 0", act1, act3);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (act3 !== 74'd0 || b_rdy !== 1'b0) begin
      n_err++; $display("FAIL reset_held: got %h rdy=%b expected 0", act3, b_rdy);
    end
    #2 reset = 1'b1;
    step();
    n_cmp++;
    if (b_ov !== 1'b0 || act3 !== exp3() || act1 !== exp1()) begin
      n_err++; $display("FAIL reset_release_stall: got %h expected %h", act3, exp3());
    end
    stall = 1'b0; in_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      stall    = ($urandom_range(0, 9) < 3);
      flush    = ($urandom_range(0, 19) == 0);
      ctrl_in  = 2'($urandom);
      rd_in    = 5'($urandom);
      data_in  = {$urandom, $urandom};
      #1;
      n_cmp++;
      if ({a_rdy, b_rdy} !== {2{~stall}}) begin
        n_err++; $display("FAIL rand_ready k=%0d: got %b expected %b", k, {a_rdy, b_rdy}, {2{~stall}});
      end
      step();
      n_cmp++;
      if (act3 !== exp3()) begin n_err++; $display("FAIL rand_d3 k=%0d: got %h expected %h", k, act3, exp3()); end
      n_cmp++;
      if (act1 !== exp1()) begin n_err++; $display("FAIL rand_d1 k=%0d: got %h expected %h", k, act1, exp1()); end
    end
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    ctrl_in = '0; data_in = '0; rd_in = '0;
    model_clear();
    test_reset();
    test_single();
    test_stream();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
